// File: rtl/stage_ic_pkg.sv
// Shared types for the instruction-complete stage.
//   IC_ENTRY      : one buffered functional-unit result
//   IC_CDB_PACKET : common data bus broadcast (valid + tag)
//   IC_PRF_PACKET : physical register file write port
//   IC_ROB_PACKET : reorder buffer completion strobe
package stage_ic_pkg;

    localparam int unsigned PREG_W = 6;
    localparam int unsigned ROB_W  = 5;
    localparam int unsigned XLEN   = 32;

    typedef struct packed {
        logic              has_dest;
        logic [PREG_W-1:0] preg;
        logic [ROB_W-1:0]  rob_idx;
        logic [XLEN-1:0]   data;
    } IC_ENTRY;

    typedef struct packed {
        logic              valid;
        logic [PREG_W-1:0] preg;
    } IC_CDB_PACKET;

    typedef struct packed {
        logic              we;
        logic [PREG_W-1:0] waddr;
        logic [XLEN-1:0]   wdata;
    } IC_PRF_PACKET;

    typedef struct packed {
        logic             valid;
        logic [ROB_W-1:0] idx;
    } IC_ROB_PACKET;

endpackage

// File: rtl/stage_ic_if.sv
// Result channels from the execute stage into the complete stage.
//   fu_valid/fu_has_dest/fu_preg/fu_rob_idx/fu_data : per-channel result (master drives)
//   fu_ready                                        : per-channel accept (slave drives)
// Channel i occupies bits [i*W +: W] of each packed field.
interface stage_ic_if #(
    parameter int unsigned N_FU = 2
) ();
    import stage_ic_pkg::*;

    logic [N_FU-1:0]        fu_valid;
    logic [N_FU-1:0]        fu_has_dest;
    logic [N_FU*PREG_W-1:0] fu_preg;
    logic [N_FU*ROB_W-1:0]  fu_rob_idx;
    logic [N_FU*XLEN-1:0]   fu_data;
    logic [N_FU-1:0]        fu_ready;

    modport master (
        output fu_valid, fu_has_dest, fu_preg, fu_rob_idx, fu_data,
        input  fu_ready
    );

    modport slave (
        input  fu_valid, fu_has_dest, fu_preg, fu_rob_idx, fu_data,
        output fu_ready
    );
endinterface

// File: rtl/stage_ic_fifo.sv
// Multi-push, single-pop circular buffer of IC_ENTRY.
//   clock, reset (async active-low), squash (sync flush)
//   push_valid/push_entry : up to N_FU pushes per cycle, lower index first
//   ready                 : per-channel accept, from registered count only
//   pop_valid/pop_entry   : head entry; it is popped at every edge where pop_valid is high
//   count                 : occupied entries
module stage_ic_fifo
    import stage_ic_pkg::*;
#(
    parameter int unsigned N_FU  = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       squash,
    input  logic [N_FU-1:0]            push_valid,
    input  IC_ENTRY [N_FU-1:0]         push_entry,
    output logic [N_FU-1:0]            ready,
    output logic                       pop_valid,
    output IC_ENTRY                    pop_entry,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    IC_ENTRY          entries_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [N_FU-1:0]  wr_en;
    logic [PTR_W-1:0] wr_idx [N_FU];
    logic [CNT_W-1:0] n_acc;
    logic             pop;

    // Channel i only needs i+1 free slots, which guarantees room for every
    // lower-index channel pushing in the same cycle.
    always_comb begin
        for (int i = 0; i < int'(N_FU); i++) begin
            ready[i] = (int'(DEPTH) - int'(count_q)) >= (i + 1);
        end
    end

    always_comb begin
        n_acc = '0;
        wr_en = '0;
        for (int i = 0; i < int'(N_FU); i++) begin
            wr_idx[i] = tail_q + PTR_W'(n_acc);
            wr_en[i]  = push_valid[i] && ready[i] && !squash;
            if (wr_en[i]) begin
                n_acc = n_acc + CNT_W'(1);
            end
        end

        // Pop decision uses the pre-edge count, so fresh writes are never popped.
        pop = (count_q != '0) && !squash;

        if (squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(pop);
            tail_d  = tail_q + PTR_W'(n_acc);
            count_d = count_q + n_acc - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        for (int i = 0; i < int'(N_FU); i++) begin
            if (wr_en[i]) begin
                entries_q[wr_idx[i]] <= push_entry[i];
            end
        end
    end

    assign pop_valid = pop;
    assign pop_entry = entries_q[head_q];
    assign count     = count_q;

endmodule

// File: rtl/stage_ic.sv
// Complete stage: buffers EX results and retires one per cycle by broadcasting
// on the CDB, writing the PRF and marking the ROB entry complete.
//   clock, reset (async active-low), squash (sync flush)
//   fu            : result channels from EX (slave side)
//   cdb_valid/cdb_preg                : CDB broadcast
//   prf_we/prf_waddr/prf_wdata        : PRF write port
//   rob_cmp_valid/rob_cmp_idx         : ROB completion strobe
//   count                             : occupied buffer entries
module stage_ic
    import stage_ic_pkg::*;
#(
    parameter int unsigned N_FU  = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       squash,
    stage_ic_if.slave                  fu,
    output logic                       cdb_valid,
    output logic [PREG_W-1:0]          cdb_preg,
    output logic                       prf_we,
    output logic [PREG_W-1:0]          prf_waddr,
    output logic [XLEN-1:0]            prf_wdata,
    output logic                       rob_cmp_valid,
    output logic [ROB_W-1:0]           rob_cmp_idx,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    IC_ENTRY [N_FU-1:0] push_entry;
    logic [N_FU-1:0]    ready;
    logic               pop_valid;
    IC_ENTRY            pop_entry;

    IC_CDB_PACKET cdb_q, cdb_d;
    IC_PRF_PACKET prf_q, prf_d;
    IC_ROB_PACKET rob_q, rob_d;

    always_comb begin
        for (int i = 0; i < int'(N_FU); i++) begin
            push_entry[i].has_dest = fu.fu_has_dest[i];
            push_entry[i].preg     = fu.fu_preg[i*PREG_W +: PREG_W];
            push_entry[i].rob_idx  = fu.fu_rob_idx[i*ROB_W +: ROB_W];
            push_entry[i].data     = fu.fu_data[i*XLEN +: XLEN];
        end
    end

    stage_ic_fifo #(
        .N_FU  (N_FU),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .squash     (squash),
        .push_valid (fu.fu_valid),
        .push_entry (push_entry),
        .ready      (ready),
        .pop_valid  (pop_valid),
        .pop_entry  (pop_entry),
        .count      (count)
    );

    assign fu.fu_ready = ready;

    // Output packets hold a popped entry for exactly one cycle; idle cycles
    // and squash clear the whole packet, not just the valids.
    always_comb begin
        cdb_d = '0;
        prf_d = '0;
        rob_d = '0;
        if (pop_valid) begin
            cdb_d.valid = pop_entry.has_dest;
            cdb_d.preg  = pop_entry.preg;
            prf_d.we    = pop_entry.has_dest;
            prf_d.waddr = pop_entry.preg;
            prf_d.wdata = pop_entry.data;
            rob_d.valid = 1'b1;
            rob_d.idx   = pop_entry.rob_idx;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cdb_q <= '0;
            prf_q <= '0;
            rob_q <= '0;
        end else begin
            cdb_q <= cdb_d;
            prf_q <= prf_d;
            rob_q <= rob_d;
        end
    end

    assign cdb_valid     = cdb_q.valid;
    assign cdb_preg      = cdb_q.preg;
    assign prf_we        = prf_q.we;
    assign prf_waddr     = prf_q.waddr;
    assign prf_wdata     = prf_q.wdata;
    assign rob_cmp_valid = rob_q.valid;
    assign rob_cmp_idx   = rob_q.idx;

endmodule

// File: tb/tb_stage_ic.sv
module tb_stage_ic;
    import stage_ic_pkg::*;

    localparam int unsigned N_FU  = 2;
    localparam int unsigned DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic squash = 1'b0;
    logic              cdb_valid, prf_we, rob_cmp_valid;
    logic [PREG_W-1:0] cdb_preg, prf_waddr;
    logic [XLEN-1:0]   prf_wdata;
    logic [ROB_W-1:0]  rob_cmp_idx;
    logic [2:0]        count;

    always #5 clock = ~clock;

    stage_ic_if #(.N_FU(N_FU)) fu_bus ();

    stage_ic #(.N_FU(N_FU), .DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .squash        (squash),
        .fu            (fu_bus),
        .cdb_valid     (cdb_valid),
        .cdb_preg      (cdb_preg),
        .prf_we        (prf_we),
        .prf_waddr     (prf_waddr),
        .prf_wdata     (prf_wdata),
        .rob_cmp_valid (rob_cmp_valid),
        .rob_cmp_idx   (rob_cmp_idx),
        .count         (count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a FIFO of results plus the one entry being retired.
    typedef struct {
        bit has_dest;
        int preg;
        int rob;
        int data;
    } ent_t;

    ent_t mq[$];
    bit   m_v;
    ent_t m_out;
    int   acc_tags[$];

    task automatic drive(int ch, bit v, bit hd, int preg, int rob, int data);
        fu_bus.fu_valid[ch]                    = v;
        fu_bus.fu_has_dest[ch]                 = hd;
        fu_bus.fu_preg[ch*PREG_W +: PREG_W]    = PREG_W'(preg);
        fu_bus.fu_rob_idx[ch*ROB_W +: ROB_W]   = ROB_W'(rob);
        fu_bus.fu_data[ch*XLEN +: XLEN]        = XLEN'(data);
    endtask

    task automatic idle();
        fu_bus.fu_valid    = '0;
        fu_bus.fu_has_dest = '0;
        fu_bus.fu_preg     = '0;
        fu_bus.fu_rob_idx  = '0;
        fu_bus.fu_data     = '0;
    endtask

    function automatic logic [N_FU-1:0] model_ready();
        logic [N_FU-1:0] r;
        for (int i = 0; i < int'(N_FU); i++) r[i] = (int'(DEPTH) - mq.size()) >= (i + 1);
        return r;
    endfunction

    // Advance the model by one rising edge with the currently driven inputs,
    // then let the DUT take the same edge.
    task automatic step();
        int   room;
        ent_t e;
        room = int'(DEPTH) - mq.size();
        if (squash) begin
            mq.delete();
            m_v = 1'b0;
        end else begin
            if (mq.size() > 0) begin
                m_out = mq.pop_front();
                m_v   = 1'b1;
            end else begin
                m_v = 1'b0;
            end
            for (int ch = 0; ch < int'(N_FU); ch++) begin
                if (fu_bus.fu_valid[ch] && room >= ch + 1) begin
                    e.has_dest = fu_bus.fu_has_dest[ch];
                    e.preg     = int'(fu_bus.fu_preg[ch*PREG_W +: PREG_W]);
                    e.rob      = int'(fu_bus.fu_rob_idx[ch*ROB_W +: ROB_W]);
                    e.data     = int'(fu_bus.fu_data[ch*XLEN +: XLEN]);
                    mq.push_back(e);
                    acc_tags.push_back(e.preg);
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        // Power-on reset state.
        #2;
        checks++;
        if ({cdb_valid, prf_we, rob_cmp_valid} !== 3'b000 || cdb_preg !== '0 || prf_waddr !== '0
            || prf_wdata !== '0 || rob_cmp_idx !== '0) begin
            errors++; $display("FAIL reset_outputs: got v=%b tag=%0d data=%0h rob=%0d expected all 0",
                               {cdb_valid, prf_we, rob_cmp_valid}, cdb_preg, prf_wdata, rob_cmp_idx);
        end
        checks++;
        if (count !== 3'd0 || fu_bus.fu_ready !== 2'b11) begin
            errors++; $display("FAIL reset_count_ready: got count=%0d ready=%b expected 0/11", count, fu_bus.fu_ready);
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;

        // Build traffic: count=2 with a live broadcast, then reset asynchronously.
        drive(0, 1, 1, 11, 3, 111);
        step();
        drive(0, 1, 1, 12, 4, 222);
        drive(1, 1, 1, 13, 5, 333);
        step();
        idle();
        checks++;
        if (int'(count) != 2 || rob_cmp_valid !== 1'b1 || cdb_preg !== 6'd11) begin
            errors++; $display("FAIL reset_pretraffic: got count=%0d rob_v=%b tag=%0d expected 2/1/11", count, rob_cmp_valid, cdb_preg);
        end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({cdb_valid, prf_we, rob_cmp_valid} !== 3'b000 || cdb_preg !== '0 || prf_wdata !== '0
            || rob_cmp_idx !== '0 || count !== 3'd0 || fu_bus.fu_ready !== 2'b11) begin
            errors++; $display("FAIL reset_async: got v=%b count=%0d ready=%b expected 000/0/11",
                               {cdb_valid, prf_we, rob_cmp_valid}, count, fu_bus.fu_ready);
        end
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b1;
        mq.delete();
        m_v = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({cdb_valid, prf_we, rob_cmp_valid} !== 3'b000 || count !== 3'd0) begin
                errors++; $display("FAIL reset_stale: got v=%b count=%0d expected 000/0",
                                   {cdb_valid, prf_we, rob_cmp_valid}, count);
            end
        end
    endtask

    task automatic test_single();
        drive(0, 1, 1, 33, 2, 10);
        step();
        idle();
        checks++;
        if (rob_cmp_valid !== 1'b0 || cdb_valid !== 1'b0) begin
            errors++; $display("FAIL single_no_bypass: got rob_v=%b cdb_v=%b expected 0/0", rob_cmp_valid, cdb_valid);
        end
        step();
        checks++;
        if (cdb_valid !== 1'b1 || cdb_preg !== 6'd33 || prf_we !== 1'b1 || prf_waddr !== 6'd33
            || prf_wdata !== 32'd10 || rob_cmp_valid !== 1'b1 || rob_cmp_idx !== 5'd2) begin
            errors++; $display("FAIL single_out: got cdb=%b/%0d prf=%b/%0d/%0d rob=%b/%0d expected 1/33 1/33/10 1/2",
                               cdb_valid, cdb_preg, prf_we, prf_waddr, prf_wdata, rob_cmp_valid, rob_cmp_idx);
        end
        step();
        checks++;
        if ({cdb_valid, prf_we, rob_cmp_valid} !== 3'b000) begin
            errors++; $display("FAIL single_one_cycle: got v=%b expected 000", {cdb_valid, prf_we, rob_cmp_valid});
        end
    endtask

    task automatic test_dual();
        drive(0, 1, 1, 32, 0, 5);
        drive(1, 1, 1, 40, 1, 35);
        step();
        idle();
        step();
        checks++;
        if (cdb_valid !== 1'b1 || cdb_preg !== 6'd32 || prf_wdata !== 32'd5 || rob_cmp_idx !== 5'd0) begin
            errors++; $display("FAIL dual_first: got %b/%0d/%0d/%0d expected 1/32/5/0", cdb_valid, cdb_preg, prf_wdata, rob_cmp_idx);
        end
        step();
        checks++;
        if (cdb_valid !== 1'b1 || cdb_preg !== 6'd40 || prf_wdata !== 32'd35 || rob_cmp_idx !== 5'd1) begin
            errors++; $display("FAIL dual_second: got %b/%0d/%0d/%0d expected 1/40/35/1", cdb_valid, cdb_preg, prf_wdata, rob_cmp_idx);
        end
        step();
        checks++;
        if (rob_cmp_valid !== 1'b0 || count !== 3'd0) begin
            errors++; $display("FAIL dual_drained: got rob_v=%b count=%0d expected 0/0", rob_cmp_valid, count);
        end
    endtask

    task automatic test_saturate();
        int bq[$];
        int tag;
        int guard;
        acc_tags.delete();
        tag = 1;
        for (int c = 0; c < 6; c++) begin
            drive(0, 1, 1, tag, tag, tag * 7);
            drive(1, 1, 1, tag + 1, tag + 1, (tag + 1) * 7);
            tag += 2;
            step();
            if (cdb_valid) bq.push_back(int'(cdb_preg));
            checks++;
            if (int'(count) != mq.size() || fu_bus.fu_ready !== model_ready()) begin
                errors++; $display("FAIL sat_count_ready: cycle %0d got count=%0d ready=%b expected %0d/%b",
                                   c, count, fu_bus.fu_ready, mq.size(), model_ready());
            end
        end
        checks++;
        if (count !== 3'd3 || fu_bus.fu_ready !== 2'b01) begin
            errors++; $display("FAIL sat_limit: got count=%0d ready=%b expected 3/01", count, fu_bus.fu_ready);
        end
        idle();
        guard = 0;
        while ((count != 3'd0 || rob_cmp_valid) && guard < 12) begin
            step();
            if (cdb_valid) bq.push_back(int'(cdb_preg));
            guard++;
        end
        checks++;
        if (guard >= 12) begin
            errors++; $display("FAIL sat_drain_timeout: got count=%0d expected 0", count);
        end
        checks++;
        if (bq.size() != acc_tags.size() || acc_tags.size() != 8) begin
            errors++; $display("FAIL sat_bcast_count: got %0d broadcasts expected %0d (8 accepted)", bq.size(), acc_tags.size());
        end
        for (int k = 0; k < bq.size() && k < acc_tags.size(); k++) begin
            checks++;
            if (bq[k] != acc_tags[k]) begin
                errors++; $display("FAIL sat_order[%0d]: got tag %0d expected %0d", k, bq[k], acc_tags[k]);
            end
        end
    endtask

    task automatic test_no_dest();
        drive(1, 1, 0, 20, 7, 99);
        step();
        idle();
        step();
        checks++;
        if (rob_cmp_valid !== 1'b1 || rob_cmp_idx !== 5'd7 || cdb_valid !== 1'b0 || prf_we !== 1'b0) begin
            errors++; $display("FAIL no_dest: got rob=%b/%0d cdb_v=%b prf_we=%b expected 1/7 0 0",
                               rob_cmp_valid, rob_cmp_idx, cdb_valid, prf_we);
        end
        step();
    endtask

    task automatic test_squash();
        int seen;
        for (int c = 0; c < 3; c++) begin
            drive(0, 1, 1, 50 + 2 * c, c, c);
            drive(1, 1, 1, 51 + 2 * c, c + 8, c + 8);
            step();
        end
        checks++;
        if (count !== 3'd3) begin
            errors++; $display("FAIL squash_fill: got count=%0d expected 3", count);
        end
        idle();
        drive(0, 1, 1, 63, 30, 1234);
        squash = 1'b1;
        step();
        squash = 1'b0;
        idle();
        checks++;
        if (count !== 3'd0 || {cdb_valid, prf_we, rob_cmp_valid} !== 3'b000 || fu_bus.fu_ready !== 2'b11) begin
            errors++; $display("FAIL squash_clear: got count=%0d v=%b ready=%b expected 0/000/11",
                               count, {cdb_valid, prf_we, rob_cmp_valid}, fu_bus.fu_ready);
        end
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (cdb_valid || rob_cmp_valid || prf_we) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL squash_leak: got %0d broadcasts after squash expected 0", seen);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int ch = 0; ch < int'(N_FU); ch++) begin
                drive(ch, bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 3) != 0),
                      int'($urandom_range(0, 63)), int'($urandom_range(0, 31)), int'($urandom));
            end
            squash = ($urandom_range(0, 19) == 0);
            step();
            checks++;
            if (rob_cmp_valid !== m_v || cdb_valid !== (m_v && m_out.has_dest)
                || prf_we !== (m_v && m_out.has_dest)) begin
                errors++; $display("FAIL rand_valids: cycle %0d got rob=%b cdb=%b we=%b expected %b/%b",
                                   c, rob_cmp_valid, cdb_valid, prf_we, m_v, m_v && m_out.has_dest);
            end
            if (m_v) begin
                checks++;
                if (int'(rob_cmp_idx) != m_out.rob || int'(cdb_preg) != m_out.preg
                    || int'(prf_waddr) != m_out.preg || prf_wdata !== XLEN'(m_out.data)) begin
                    errors++; $display("FAIL rand_fields: cycle %0d got rob=%0d tag=%0d waddr=%0d data=%0h expected %0d/%0d/%0h",
                                       c, rob_cmp_idx, cdb_preg, prf_waddr, prf_wdata, m_out.rob, m_out.preg, m_out.data);
                end
            end
            checks++;
            if (int'(count) != mq.size() || fu_bus.fu_ready !== model_ready()) begin
                errors++; $display("FAIL rand_count_ready: cycle %0d got count=%0d ready=%b expected %0d/%b",
                                   c, count, fu_bus.fu_ready, mq.size(), model_ready());
            end
        end
        squash = 1'b0;
        idle();
    endtask

    initial begin
        idle();
        m_v = 1'b0;
        test_reset();
        test_single();
        test_dual();
        test_saturate();
        test_no_dest();
        test_squash();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
